// File: rtl/dice_roll_sampler.sv
// Von Neumann-whitened, rejection-sampled die roller fed from the GARO raw bit stream,
// with a repetition-count health test that latches a sticky oscillator shutdown.
module dice_roll_sampler #(
    parameter int SIDES      = 6,
    parameter int WARMUP     = 64,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_req,
    input  logic       rnd_bit,
    output logic       osc_run,
    output logic       busy,
    output logic       roll_valid,
    output logic [3:0] roll_value,
    output logic       health_fail
);

    localparam int W   = $clog2(SIDES);
    localparam int WCW = $clog2(WARMUP + 1);
    localparam int DW  = $clog2(SAMPLE_DIV + 1);
    localparam int RW  = $clog2(REP_LIMIT + 1);
    localparam int BW  = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COLLECT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state, state_nx;

    logic [WCW-1:0] warm_cnt;
    logic [DW-1:0]  div_cnt;
    logic [RW-1:0]  run_len;
    logic [BW-1:0]  bit_cnt;
    logic [W-1:0]   acc;
    logic           pair_phase;
    logic           first_bit;
    logic           prev_bit;

    logic           tick;
    logic [RW-1:0]  run_next;
    logic           trip;
    logic           vn_bit;
    logic [W-1:0]   acc_next;
    logic           full;
    logic           accept;

    // run_len==0 marks the first raw sample after COLLECT entry
    always_comb begin
        tick     = 1'b0;
        run_next = '0;
        trip     = 1'b0;
        vn_bit   = 1'b0;
        acc_next = acc;
        full     = 1'b0;
        accept   = 1'b0;
        if (state == S_COLLECT && div_cnt == DW'(SAMPLE_DIV - 1)) begin
            tick     = 1'b1;
            run_next = (run_len == '0 || rnd_bit != prev_bit) ? RW'(1) : run_len + 1'b1;
            trip     = (run_next == RW'(REP_LIMIT));
            vn_bit   = pair_phase && (first_bit != rnd_bit);
            acc_next = W'({acc, first_bit});
            full     = vn_bit && (bit_cnt == BW'(W - 1));
            accept   = full && ({{(32 - W){1'b0}}, acc_next} < 32'(SIDES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (roll_req) state_nx = S_WARMUP;
            S_WARMUP:  if (warm_cnt == WCW'(WARMUP - 1)) state_nx = S_COLLECT;
            S_COLLECT: begin
                if (trip)        state_nx = S_FAIL;
                else if (accept) state_nx = S_DONE;
            end
            S_DONE:    state_nx = S_IDLE;
            S_FAIL:    state_nx = S_FAIL;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        osc_run     = 1'b0;
        busy        = 1'b0;
        roll_valid  = 1'b0;
        health_fail = 1'b0;
        case (state)
            S_WARMUP, S_COLLECT: begin
                osc_run = 1'b1;
                busy    = 1'b1;
            end
            S_DONE: begin
                osc_run    = 1'b1;
                busy       = 1'b1;
                roll_valid = 1'b1;
            end
            S_FAIL:  health_fail = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt   <= '0;
            div_cnt    <= '0;
            run_len    <= '0;
            bit_cnt    <= '0;
            acc        <= '0;
            pair_phase <= 1'b0;
            first_bit  <= 1'b0;
            prev_bit   <= 1'b0;
            roll_value <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (roll_req) begin
                        warm_cnt   <= '0;
                        div_cnt    <= '0;
                        run_len    <= '0;
                        bit_cnt    <= '0;
                        acc        <= '0;
                        pair_phase <= 1'b0;
                    end
                end
                S_WARMUP: warm_cnt <= warm_cnt + 1'b1;
                S_COLLECT: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        run_len    <= run_next;
                        prev_bit   <= rnd_bit;
                        pair_phase <= ~pair_phase;
                        if (!pair_phase) first_bit <= rnd_bit;
                        // a full candidate always restarts accumulation, accepted or not
                        if (vn_bit) begin
                            if (full) begin
                                bit_cnt <= '0;
                                acc     <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                acc     <= acc_next;
                            end
                        end
                        if (accept && !trip) roll_value <= 4'({1'b0, acc_next} + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_roll_sampler.sv
// Self-checking bench: directed vector table plus randomized raw streams checked
// cycle by cycle against an arithmetic model of the corrector and health test.
module tb_dice_roll_sampler;

    localparam int SIDES      = 6;
    localparam int WARMUP     = 64;
    localparam int SAMPLE_DIV = 4;
    localparam int REP_LIMIT  = 32;
    localparam int W          = $clog2(SIDES);

    logic       clk;
    logic       reset;
    logic       roll_req;
    logic       rnd_bit;
    logic       osc_run;
    logic       busy;
    logic       roll_valid;
    logic [3:0] roll_value;
    logic       health_fail;

    dice_roll_sampler #(
        .SIDES(SIDES),
        .WARMUP(WARMUP),
        .SAMPLE_DIV(SAMPLE_DIV),
        .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .roll_req(roll_req),
        .rnd_bit(rnd_bit),
        .osc_run(osc_run),
        .busy(busy),
        .roll_valid(roll_valid),
        .roll_value(roll_value),
        .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] cur_val = '0;
    bit         stim[$];

    typedef struct {
        logic [31:0] pat;
        int          len;
        logic [3:0]  val;
        int          end_cyc;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [7:0] outs();
        return {osc_run, busy, roll_valid, health_fail, roll_value};
    endfunction

    task automatic check(input string name, input int cyc, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got{osc,busy,valid,hf,val}=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    // Reference: walk the raw samples in order, pairing, whitening and rejecting.
    // kind 0 = unresolved, 1 = accepted, 2 = health trip; n = deciding sample number.
    function automatic void model(output int kind, output int n, output logic [3:0] val);
        int run = 0;
        int cand = 0;
        int nb = 0;
        kind = 0;
        n = 0;
        val = '0;
        for (int i = 0; i < stim.size(); i++) begin
            run = (i > 0 && stim[i] == stim[i-1]) ? run + 1 : 1;
            if (run >= REP_LIMIT) begin
                kind = 2;
                n = i + 1;
                return;
            end
            if (i % 2 == 1 && stim[i-1] != stim[i]) begin
                cand = cand * 2 + int'(stim[i-1]);
                nb++;
                if (nb == W) begin
                    if (cand < SIDES) begin
                        kind = 1;
                        n = i + 1;
                        val = 4'(cand + 1);
                        return;
                    end
                    cand = 0;
                    nb = 0;
                end
            end
        end
    endfunction

    task automatic reset_phase();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", i, outs(), 8'h00);
            roll_req = 1'($urandom_range(1));
            rnd_bit  = 1'($urandom_range(1));
        end
        reset    = 1'b0;
        roll_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_idle", i, outs(), 8'h00);
        end
        cur_val = '0;
    endtask

    // Cycle 0 is the IDLE cycle carrying roll_req; every later cycle is checked in full.
    task automatic run_case(input string name, input int end_cyc, input logic [3:0] val,
                            input bit fail, input bit spam, input int abort_at);
        int last;
        int n;
        logic b_e, v_e, h_e;
        logic [3:0] r_e;
        @(negedge clk);
        check({name, "_idle"}, 0, outs(), {4'b0000, cur_val});
        roll_req = 1'b1;
        rnd_bit  = 1'($urandom_range(1));
        last = (abort_at > 0) ? abort_at + 40 : end_cyc + 3;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (abort_at > 0 && c > abort_at) begin
                b_e = 1'b0; v_e = 1'b0; h_e = 1'b0; r_e = '0;
            end else if (fail) begin
                b_e = (c < end_cyc); v_e = 1'b0; h_e = (c >= end_cyc); r_e = cur_val;
            end else begin
                b_e = (c <= end_cyc); v_e = (c == end_cyc); h_e = 1'b0;
                r_e = (c >= end_cyc) ? val : cur_val;
            end
            check(name, c, outs(), {b_e, b_e, v_e, h_e, r_e});
            reset    = (abort_at > 0 && c == abort_at);
            roll_req = (spam && c < end_cyc && !(abort_at > 0 && c >= abort_at))
                       ? 1'($urandom_range(1)) : 1'b0;
            n = (c - WARMUP) / SAMPLE_DIV;
            if (c > WARMUP && (c - WARMUP) % SAMPLE_DIV == 0 && n <= stim.size())
                rnd_bit = stim[n-1];
            else
                rnd_bit = 1'($urandom_range(1));
        end
        reset = 1'b0;
        if (abort_at > 0) cur_val = '0;
        else if (!fail)   cur_val = val;
    endtask

    task automatic after_fail();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fail_sticky", i, outs(), {4'b0001, cur_val});
            roll_req = 1'b1;
        end
        roll_req = 1'b0;
        reset_phase();
    endtask

    initial begin
        int kind, n, stick;
        logic [3:0] mval;
        bit b;

        reset    = 1'b1;
        roll_req = 1'b0;
        rnd_bit  = 1'b0;

        tbl[0] = '{pat: 32'b100110,           len: 6,  val: 4'd6, end_cyc: 89};
        tbl[1] = '{pat: 32'b101010010101,     len: 12, val: 4'd1, end_cyc: 113};
        tbl[2] = '{pat: 32'b1100101001010101, len: 16, val: 4'd1, end_cyc: 129};
        tbl[3] = '{pat: 32'b011001,           len: 6,  val: 4'd3, end_cyc: 89};
        tbl[4] = '{pat: 32'b101001100101,     len: 12, val: 4'd5, end_cyc: 113};

        reset_phase();

        for (int t = 0; t < 5; t++) begin
            stim.delete();
            for (int i = 0; i < tbl[t].len; i++) stim.push_back(tbl[t].pat[tbl[t].len-1-i]);
            run_case($sformatf("vec%0d", t), tbl[t].end_cyc, tbl[t].val, 1'b0, (t % 2) == 1, 0);
        end

        stim.delete();
        for (int i = 0; i < 40; i++) stim.push_back(1'b1);
        run_case("stuck_one", 193, '0, 1'b1, 1'b1, 0);
        after_fail();

        stim.delete();
        for (int i = 0; i < 6; i++) stim.push_back(tbl[0].pat[5-i]);
        run_case("abort80", 89, 4'd6, 1'b0, 1'b1, 80);

        for (int it = 0; it < 12; it++) begin
            stick = (it % 3 == 0) ? 50 : (it % 3 == 1) ? 85 : 98;
            stim.delete();
            b = 1'($urandom_range(1));
            for (int i = 0; i < 70; i++) begin
                if ($urandom_range(99) >= stick) b = ~b;
                stim.push_back(b);
            end
            model(kind, n, mval);
            while (kind == 0 && stim.size() < 200) begin
                stim.push_back(1'b0);
                stim.push_back(1'b1);
                model(kind, n, mval);
            end
            if (kind == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_model it=%0d unresolved stream of %0d samples", it, stim.size());
            end else begin
                run_case($sformatf("rand%0d", it), WARMUP + n * SAMPLE_DIV + 1, mval,
                         kind == 2, 1'($urandom_range(1)), 0);
                if (kind == 2) after_fail();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
